// File: rtl/edge_detector_array_if.sv
// Bundle of the per-channel pins of edge_detector_array.
// master drives raw inputs, mode and clear; slave is the detector itself.
interface edge_detector_array_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   data_in;
  logic [2*NUM_CH-1:0] mode;
  logic [NUM_CH-1:0]   clear;
  logic [NUM_CH-1:0]   level_out;
  logic [NUM_CH-1:0]   edge_pulse;
  logic [NUM_CH-1:0]   edge_sticky;
  logic                any_edge;

  modport master (
    output data_in, mode, clear,
    input  level_out, edge_pulse, edge_sticky, any_edge
  );

  modport slave (
    input  data_in, mode, clear,
    output level_out, edge_pulse, edge_sticky, any_edge
  );
endinterface

// File: rtl/edge_detector_array.sv
// Multi-channel edge detector: per channel a synchroniser, a debounce filter,
// a mode-qualified one-cycle edge pulse and a sticky flag with clear.
module edge_detector_array #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int RESET_VAL       = 0
) (
  input logic                 clk,
  input logic                 n_rst,
  edge_detector_array_if.slave bus
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_CH-1:0] RST_LVL = (RESET_VAL != 0) ? '1 : '0;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                  s;
  logic [NUM_CH-1:0]                  level_q, level_d;
  logic [NUM_CH-1:0]                  pulse_q, pulse_d;
  logic [NUM_CH-1:0]                  sticky_q, sticky_d;
  logic [NUM_CH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic                               any_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {SYNC_STAGES{RST_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.data_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A level change is accepted once s has differed from level_q for
  // DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
        // mode bit 0 qualifies rises, bit 1 qualifies falls
        pulse_d[i] = s[i] ? bus.mode[2*i] : bus.mode[2*i+1];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    sticky_d = (sticky_q & ~bus.clear) | pulse_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      level_q  <= RST_LVL;
      cnt_q    <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      any_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      any_q    <= |pulse_d;
    end
  end

  assign bus.level_out   = level_q;
  assign bus.edge_pulse  = pulse_q;
  assign bus.edge_sticky = sticky_q;
  assign bus.any_edge    = any_q;

endmodule

// File: tb/tb_edge_detector_array.sv
// Bench for edge_detector_array: a default-parameter instance (a) and a
// DEBOUNCE_CYCLES=4 instance (b), checked against a cycle-stamped scoreboard.
module tb_edge_detector_array;

  logic clk;
  logic n_rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  edge_detector_array_if #(.NUM_CH(4)) a_if ();
  edge_detector_array_if #(.NUM_CH(4)) b_if ();

  edge_detector_array #(
    .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VAL(0)
  ) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(a_if)
  );

  edge_detector_array #(
    .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(0)
  ) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(b_if)
  );

  typedef struct {
    int         due;
    bit         on_b;
    logic [3:0] pulse;
    logic       any;
    logic [3:0] lvl_mask;
    logic [3:0] level;
    string      tag;
  } exp_t;

  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  function automatic void push(int due, bit on_b, logic [3:0] pulse, logic any,
                               logic [3:0] lvl_mask, logic [3:0] level, string tag);
    exp_t e;
    e.due = due; e.on_b = on_b; e.pulse = pulse; e.any = any;
    e.lvl_mask = lvl_mask; e.level = level; e.tag = tag;
    sb.push_back(e);
  endfunction

  // Scoreboard: entries are compared in the cycle they fall due, #1 after the edge.
  always @(posedge clk) begin
    exp_t       e;
    logic [3:0] p, l;
    logic       an;
    cyc = cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        tests++; fails++;
        $display("FAIL %s missed: checked at cycle %0d, due %0d", e.tag, cyc, e.due);
      end else begin
        p  = e.on_b ? b_if.edge_pulse : a_if.edge_pulse;
        l  = e.on_b ? b_if.level_out  : a_if.level_out;
        an = e.on_b ? b_if.any_edge   : a_if.any_edge;
        tests++;
        if (p !== e.pulse) begin
          fails++;
          $display("FAIL %s edge_pulse cyc=%0d got %b want %b", e.tag, cyc, p, e.pulse);
        end
        tests++;
        if (an !== e.any) begin
          fails++;
          $display("FAIL %s any_edge cyc=%0d got %b want %b", e.tag, cyc, an, e.any);
        end
        tests++;
        if ((l & e.lvl_mask) !== e.level) begin
          fails++;
          $display("FAIL %s level_out cyc=%0d got %b want %b (mask %b)",
                   e.tag, cyc, l & e.lvl_mask, e.level, e.lvl_mask);
        end
      end
    end
  end

  task automatic wait_drain(string tag);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s drain_timeout got %0d pending want 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    a_if.data_in = '0; a_if.mode = '0; a_if.clear = '0;
    b_if.data_in = '0; b_if.mode = '0; b_if.clear = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_if.level_out, a_if.edge_pulse, a_if.edge_sticky, a_if.any_edge} !== 13'h0) begin
      fails++;
      $display("FAIL reset_a got %b/%b/%b/%b want all 0",
               a_if.level_out, a_if.edge_pulse, a_if.edge_sticky, a_if.any_edge);
    end
    tests++;
    if ({b_if.level_out, b_if.edge_pulse, b_if.edge_sticky, b_if.any_edge} !== 13'h0) begin
      fails++;
      $display("FAIL reset_b got %b/%b/%b/%b want all 0",
               b_if.level_out, b_if.edge_pulse, b_if.edge_sticky, b_if.any_edge);
    end
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({a_if.level_out, a_if.edge_pulse} !== 8'h0) begin
      fails++;
      $display("FAIL post_reset_idle got %b want 00000000", {a_if.level_out, a_if.edge_pulse});
    end
  endtask

  task automatic test_rise();
    int c;
    a_if.mode = 8'h01;
    c = cyc;
    a_if.data_in[0] = 1'b1;
    push(c + 2, 0, 4'b0000, 0, 4'b0001, 4'b0000, "rise_early");
    push(c + 3, 0, 4'b0001, 1, 4'b0001, 4'b0001, "rise_pulse");
    push(c + 4, 0, 4'b0000, 0, 4'b0001, 4'b0001, "rise_width");
    wait_drain("rise");
    repeat (3) @(negedge clk);
    tests++;
    if (a_if.edge_sticky[0] !== 1'b1) begin
      fails++;
      $display("FAIL rise_sticky_held got %b want 1", a_if.edge_sticky[0]);
    end
    a_if.clear[0] = 1'b1;
    @(negedge clk);
    a_if.clear[0] = 1'b0;
    tests++;
    if (a_if.edge_sticky[0] !== 1'b0) begin
      fails++;
      $display("FAIL rise_sticky_clear got %b want 0", a_if.edge_sticky[0]);
    end
    a_if.mode = 8'h00;
    c = cyc;
    a_if.data_in[0] = 1'b0;
    push(c + 3, 0, 4'b0000, 0, 4'b0001, 4'b0000, "off_fall");
    wait_drain("off_fall");
  endtask

  task automatic test_modes();
    logic [1:0] m;
    int c;
    for (int k = 0; k < 4; k++) begin
      m = 2'(k);
      a_if.mode = {4'b0000, m, 2'b00};
      c = cyc;
      a_if.data_in[1] = 1'b1;
      push(c + 3, 0, m[0] ? 4'b0010 : 4'b0000, m[0], 4'b0010, 4'b0010, "mode_rise");
      push(c + 4, 0, 4'b0000, 0, 4'b0010, 4'b0010, "mode_rise_w");
      repeat (10) @(negedge clk);
      c = cyc;
      a_if.data_in[1] = 1'b0;
      push(c + 3, 0, m[1] ? 4'b0010 : 4'b0000, m[1], 4'b0010, 4'b0000, "mode_fall");
      push(c + 4, 0, 4'b0000, 0, 4'b0010, 4'b0000, "mode_fall_w");
      wait_drain("modes");
    end
  endtask

  task automatic test_debounce();
    int c;
    b_if.mode = 8'h01;
    c = cyc;
    b_if.data_in[0] = 1'b1;
    for (int d = 3; d <= 7; d++)
      push(c + d, 1, 4'b0000, 0, 4'b0001, 4'b0000, "glitch");
    repeat (3) @(negedge clk);
    b_if.data_in[0] = 1'b0;
    wait_drain("glitch");
    repeat (2) @(negedge clk);
    c = cyc;
    b_if.data_in[0] = 1'b1;
    push(c + 5, 1, 4'b0000, 0, 4'b0001, 4'b0000, "deb_early");
    push(c + 6, 1, 4'b0001, 1, 4'b0001, 4'b0001, "deb_pulse");
    push(c + 7, 1, 4'b0000, 0, 4'b0001, 4'b0001, "deb_width");
    repeat (6) @(negedge clk);
    c = cyc;
    b_if.data_in[0] = 1'b0;
    push(c + 5, 1, 4'b0000, 0, 4'b0001, 4'b0001, "deb_fall_early");
    push(c + 6, 1, 4'b0000, 0, 4'b0001, 4'b0000, "deb_fall");
    wait_drain("debounce");
  endtask

  task automatic test_sticky_clear();
    int c;
    a_if.mode = 8'h10;
    c = cyc;
    a_if.data_in[2] = 1'b1;
    push(c + 3, 0, 4'b0100, 1, 4'b0100, 4'b0100, "sticky_pulse");
    repeat (2) @(negedge clk);
    a_if.clear[2] = 1'b1;
    @(negedge clk);
    tests++;
    if (a_if.edge_sticky[2] !== 1'b1) begin
      fails++;
      $display("FAIL sticky_set_wins got %b want 1", a_if.edge_sticky[2]);
    end
    @(negedge clk);
    tests++;
    if (a_if.edge_sticky[2] !== 1'b0) begin
      fails++;
      $display("FAIL sticky_clear_next got %b want 0", a_if.edge_sticky[2]);
    end
    a_if.clear[2] = 1'b0;
    wait_drain("sticky");
  endtask

  task automatic test_simultaneous();
    int c;
    a_if.mode = 8'h41;
    c = cyc;
    a_if.data_in[0] = 1'b1;
    a_if.data_in[3] = 1'b1;
    push(c + 3, 0, 4'b1001, 1, 4'b1001, 4'b1001, "simul_pulse");
    push(c + 4, 0, 4'b0000, 0, 4'b1001, 4'b1001, "simul_width");
    wait_drain("simul");
  endtask

  task automatic test_back_to_back();
    int c;
    a_if.mode = 8'h0C;
    c = cyc;
    for (int j = 0; j < 6; j++) begin
      a_if.data_in[1] = (j % 2 == 0);
      push(c + j + 3, 0, 4'b0010, 1, 4'b0010, (j % 2 == 0) ? 4'b0010 : 4'b0000, "b2b");
      @(negedge clk);
    end
    push(c + 9, 0, 4'b0000, 0, 4'b0010, 4'b0000, "b2b_end");
    wait_drain("b2b");
  endtask

  task automatic test_reset_midcount();
    int c;
    a_if.mode = 8'h0C;
    b_if.mode = 8'h01;
    c = cyc;
    a_if.data_in[1] = 1'b1;
    b_if.data_in[0] = 1'b1;
    push(c + 3, 0, 4'b0010, 1, 4'b0010, 4'b0010, "pre_rst_pulse");
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    #1;
    tests++;
    if ({a_if.level_out, a_if.edge_pulse, a_if.edge_sticky, a_if.any_edge} !== 13'h0) begin
      fails++;
      $display("FAIL midpulse_reset_a got %b/%b/%b/%b want all 0",
               a_if.level_out, a_if.edge_pulse, a_if.edge_sticky, a_if.any_edge);
    end
    tests++;
    if ({b_if.level_out, b_if.edge_pulse, b_if.edge_sticky, b_if.any_edge} !== 13'h0) begin
      fails++;
      $display("FAIL midcount_reset_b got %b/%b/%b/%b want all 0",
               b_if.level_out, b_if.edge_pulse, b_if.edge_sticky, b_if.any_edge);
    end
    a_if.data_in = 4'hF; a_if.mode = 8'h55;
    b_if.data_in = 4'hF; b_if.mode = 8'h55;
    repeat (2) @(negedge clk);
    c = cyc;
    n_rst = 1'b1;
    push(c + 3, 0, 4'hF, 1, 4'hF, 4'hF, "rel_a_pulse");
    push(c + 4, 0, 4'h0, 0, 4'hF, 4'hF, "rel_a_width");
    push(c + 5, 1, 4'h0, 0, 4'hF, 4'h0, "rel_b_early");
    push(c + 6, 1, 4'hF, 1, 4'hF, 4'hF, "rel_b_pulse");
    push(c + 7, 1, 4'h0, 0, 4'hF, 4'hF, "rel_b_width");
    wait_drain("reset_release");
  endtask

  initial begin
    test_reset();
    test_rise();
    test_modes();
    test_debounce();
    test_sticky_clear();
    test_simultaneous();
    test_back_to_back();
    test_reset_midcount();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
